// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared fetch/decode pipeline types and constants
package cpu_pipe_pkg;

  localparam int VADDR_WIDTH = 32;
  localparam int REG_WIDTH   = 32;

  // All-zero encoding is treated as a no-op by decode.
  localparam logic [REG_WIDTH-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [REG_WIDTH-1:0]   instr;
    logic [VADDR_WIDTH-1:0] pc;
    logic                   itlb_miss;
  } fetch_entry_t;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_FAULT = 1'b1
  } fq_state_t;

endpackage

// File: rtl/cpu_fetch_decode_queue_if.sv
// rtl/cpu_fetch_decode_queue_if.sv - fetch-side and decode-side signals of the instruction queue
interface cpu_fetch_decode_queue_if
  import cpu_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = VADDR_WIDTH,
  parameter int DATA_WIDTH = REG_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic                  fetch_cache_hit;
  logic                  fetch_tlb_hit;
  logic                  tlb_enable;
  logic                  flush;
  logic                  fetch_accept;
  logic                  fetch_stall;
  logic                  dec_valid;
  logic [DATA_WIDTH-1:0] dec_instr;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic                  dec_itlb_miss;
  logic                  dec_ready;
  logic [31:0]           miss_cycles;

  // Queue-side view.
  modport slave (
    input  fetch_pc, fetch_instr, fetch_cache_hit, fetch_tlb_hit, tlb_enable, flush, dec_ready,
    output fetch_accept, fetch_stall, dec_valid, dec_instr, dec_pc, dec_itlb_miss, miss_cycles
  );

  // Pipeline-side view (fetch stage, decode stage, redirect source).
  modport master (
    output fetch_pc, fetch_instr, fetch_cache_hit, fetch_tlb_hit, tlb_enable, flush, dec_ready,
    input  fetch_accept, fetch_stall, dec_valid, dec_instr, dec_pc, dec_itlb_miss, miss_cycles
  );

endinterface

// File: rtl/cpu_fetch_decode_queue_fifo.sv
// rtl/cpu_fetch_decode_queue_fifo.sv - power-of-two synchronous FIFO with clear and head output
module cpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally at DEPTH; clear drops entries but leaves storage as-is.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cpu_fetch_decode_queue.sv
// rtl/cpu_fetch_decode_queue.sv - fetch-to-decode instruction queue with fault halt and flush
module cpu_fetch_decode_queue
  import cpu_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = VADDR_WIDTH,
  parameter int DATA_WIDTH = REG_WIDTH,
  parameter int DEPTH      = 2
) (
  input logic                       clock,
  input logic                       reset,
  cpu_fetch_decode_queue_if.slave   bus
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;

  fq_state_t            state;
  logic [CW-1:0]        count;
  logic [ENTRY_W-1:0]   wr_word;
  logic [ENTRY_W-1:0]   head_word;
  logic [31:0]          miss_q;
  logic                 tlb_ok;
  logic                 full;
  logic                 run_open;
  logic                 enq;
  logic                 deq;
  logic                 miss;
  logic                 valid;

  assign tlb_ok   = bus.fetch_tlb_hit | ~bus.tlb_enable;
  assign full     = (count == CW'(DEPTH));
  // Reset gates accept so the PC register never advances while the queue is held in reset.
  assign run_open = (state == FQ_RUN) & ~full & ~bus.flush & ~reset;
  assign enq      = run_open & bus.fetch_cache_hit;
  assign miss     = run_open & ~bus.fetch_cache_hit;
  assign valid    = (count != '0);
  assign deq      = valid & bus.dec_ready & ~bus.flush;

  // A translation fault is queued as a NOP carrying the fault flag so decode raises it in order.
  assign wr_word = tlb_ok ? {bus.fetch_instr, bus.fetch_pc, 1'b0}
                          : {DATA_WIDTH'(NOP_INSTR), bus.fetch_pc, 1'b1};

  cpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .push  (enq),
    .pop   (deq),
    .wdata (wr_word),
    .head  (head_word),
    .count (count)
  );

  // Fetch halts after queueing a faulting entry until a redirect arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FQ_RUN;
    end else if (bus.flush) begin
      state <= FQ_RUN;
    end else if (enq && !tlb_ok) begin
      state <= FQ_FAULT;
    end
  end

  // Saturating count of cycles fetch was ready to enqueue but the I-cache missed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_q <= '0;
    end else if (miss && (miss_q != '1)) begin
      miss_q <= miss_q + 32'd1;
    end
  end

  assign bus.fetch_accept  = enq;
  assign bus.fetch_stall   = full | (state == FQ_FAULT);
  assign bus.dec_valid     = valid;
  assign bus.dec_instr     = valid ? head_word[ENTRY_W-1 -: DATA_WIDTH] : DATA_WIDTH'(NOP_INSTR);
  assign bus.dec_pc        = valid ? head_word[ADDR_WIDTH:1] : '0;
  assign bus.dec_itlb_miss = valid & head_word[0];
  assign bus.miss_cycles   = miss_q;

endmodule

// File: tb/tb_cpu_fetch_decode_queue.sv
// tb/tb_cpu_fetch_decode_queue.sv - directed self-checking bench for the fetch/decode queue
module tb_cpu_fetch_decode_queue;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  cpu_fetch_decode_queue_if bus ();

  cpu_fetch_decode_queue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset               = 1'b1;
    bus.fetch_pc        = 32'h0;
    bus.fetch_instr     = 32'h0;
    bus.fetch_cache_hit = 1'b1;
    bus.fetch_tlb_hit   = 1'b0;
    bus.tlb_enable      = 1'b0;
    bus.flush           = 1'b0;
    bus.dec_ready       = 1'b0;
    repeat (2) tick();

    chk("rst_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_instr", bus.dec_instr, 32'h0);
    chk("rst_pc", bus.dec_pc, 32'h0);
    chk("rst_itlb", 32'(bus.dec_itlb_miss), 32'd0);
    chk("rst_accept", 32'(bus.fetch_accept), 32'd0);
    chk("rst_stall", 32'(bus.fetch_stall), 32'd0);
    chk("rst_miss", bus.miss_cycles, 32'd0);

    // Fill with decode stalled.
    reset = 1'b0;
    bus.fetch_pc = 32'h1000; bus.fetch_instr = 32'h00A00093;
    #1;
    chk("fill0_accept", 32'(bus.fetch_accept), 32'd1);
    chk("fill0_stall", 32'(bus.fetch_stall), 32'd0);
    tick();
    chk("fill0_valid", 32'(bus.dec_valid), 32'd1);
    chk("fill0_pc", bus.dec_pc, 32'h1000);
    chk("fill0_instr", bus.dec_instr, 32'h00A00093);
    bus.fetch_pc = 32'h1004; bus.fetch_instr = 32'h00B00113;
    #1;
    chk("fill1_accept", 32'(bus.fetch_accept), 32'd1);
    tick();
    bus.fetch_pc = 32'h1008;
    #1;
    chk("full_stall", 32'(bus.fetch_stall), 32'd1);
    chk("full_accept", 32'(bus.fetch_accept), 32'd0);
    tick();
    chk("full_head_pc", bus.dec_pc, 32'h1000);
    chk("full_valid", 32'(bus.dec_valid), 32'd1);
    chk("full_miss", bus.miss_cycles, 32'd0);

    bus.flush = 1'b1;
    #1;
    chk("flush0_accept", 32'(bus.fetch_accept), 32'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush0_valid", 32'(bus.dec_valid), 32'd0);
    chk("flush0_stall", 32'(bus.fetch_stall), 32'd0);

    // Streaming with decode always ready; crosses pointer wrap several times.
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.fetch_pc    = 32'(4 * i);
      bus.fetch_instr = 32'h100 + 32'(i);
      #1;
      chk("stream_stall", 32'(bus.fetch_stall), 32'd0);
      chk("stream_accept", 32'(bus.fetch_accept), 32'd1);
      tick();
      chk("stream_pc", bus.dec_pc, 32'(4 * i));
      chk("stream_instr", bus.dec_instr, 32'h100 + 32'(i));
    end

    // Cache misses: one draining cycle, then five with the queue empty.
    bus.fetch_cache_hit = 1'b0;
    #1;
    chk("drain_accept", 32'(bus.fetch_accept), 32'd0);
    tick();
    chk("drain_valid", 32'(bus.dec_valid), 32'd0);
    chk("drain_miss", bus.miss_cycles, 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("miss_valid", 32'(bus.dec_valid), 32'd0);
      chk("miss_instr", bus.dec_instr, 32'h0);
      chk("miss_accept", 32'(bus.fetch_accept), 32'd0);
      tick();
    end
    chk("miss_total", bus.miss_cycles, 32'd6);

    // I-TLB miss at 0x2000.
    bus.fetch_cache_hit = 1'b1;
    bus.dec_ready       = 1'b0;
    bus.tlb_enable      = 1'b1;
    bus.fetch_tlb_hit   = 1'b0;
    bus.fetch_pc        = 32'h2000;
    bus.fetch_instr     = 32'hDEADBEEF;
    #1;
    chk("fault_accept", 32'(bus.fetch_accept), 32'd1);
    tick();
    chk("fault_valid", 32'(bus.dec_valid), 32'd1);
    chk("fault_itlb", 32'(bus.dec_itlb_miss), 32'd1);
    chk("fault_instr", bus.dec_instr, 32'h0);
    chk("fault_pc", bus.dec_pc, 32'h2000);
    chk("fault_stall", 32'(bus.fetch_stall), 32'd1);
    bus.fetch_tlb_hit = 1'b1;
    bus.fetch_pc      = 32'h2004;
    bus.fetch_instr   = 32'h00000033;
    #1;
    chk("halt_accept", 32'(bus.fetch_accept), 32'd0);
    chk("halt_stall", 32'(bus.fetch_stall), 32'd1);
    tick();
    chk("halt_head", bus.dec_pc, 32'h2000);
    bus.dec_ready = 1'b1;
    tick();
    chk("halt_drained", 32'(bus.dec_valid), 32'd0);
    chk("halt_drained_stall", 32'(bus.fetch_stall), 32'd1);
    bus.flush     = 1'b1;
    bus.dec_ready = 1'b0;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("unhalt_stall", 32'(bus.fetch_stall), 32'd0);
    bus.fetch_pc = 32'h3000; bus.fetch_instr = 32'h00300193;
    #1;
    chk("resume_accept", 32'(bus.fetch_accept), 32'd1);
    tick();
    chk("resume_pc", bus.dec_pc, 32'h3000);
    chk("resume_itlb", 32'(bus.dec_itlb_miss), 32'd0);
    chk("resume_instr", bus.dec_instr, 32'h00300193);

    // Two entries, then flush + dec_ready + cache hit together.
    bus.fetch_pc = 32'h3004;
    tick();
    #1;
    chk("two_stall", 32'(bus.fetch_stall), 32'd1);
    bus.flush     = 1'b1;
    bus.dec_ready = 1'b1;
    bus.fetch_pc  = 32'h3008;
    #1;
    chk("flush_full_accept", 32'(bus.fetch_accept), 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.dec_ready = 1'b0;
    #1;
    chk("flush_full_valid", 32'(bus.dec_valid), 32'd0);
    chk("flush_full_stall", 32'(bus.fetch_stall), 32'd0);
    bus.fetch_pc = 32'h4000;
    #1;
    chk("post_flush_accept", 32'(bus.fetch_accept), 32'd1);
    tick();
    chk("post_flush_pc", bus.dec_pc, 32'h4000);

    // Flush with room in the queue must still block the enqueue.
    bus.flush     = 1'b1;
    bus.dec_ready = 1'b1;
    bus.fetch_pc  = 32'h4004;
    #1;
    chk("flush_one_accept", 32'(bus.fetch_accept), 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.dec_ready = 1'b0;
    chk("flush_one_valid", 32'(bus.dec_valid), 32'd0);

    // Fill, then asynchronous reset mid-cycle.
    bus.fetch_pc = 32'h5000;
    tick();
    bus.fetch_pc = 32'h5004;
    tick();
    #1;
    chk("pre_rst_stall", 32'(bus.fetch_stall), 32'd1);
    chk("pre_rst_valid", 32'(bus.dec_valid), 32'd1);
    chk("pre_rst_miss", bus.miss_cycles, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.dec_valid), 32'd0);
    chk("arst_pc", bus.dec_pc, 32'h0);
    chk("arst_instr", bus.dec_instr, 32'h0);
    chk("arst_itlb", 32'(bus.dec_itlb_miss), 32'd0);
    chk("arst_miss", bus.miss_cycles, 32'd0);
    chk("arst_stall", 32'(bus.fetch_stall), 32'd0);
    chk("arst_accept", 32'(bus.fetch_accept), 32'd0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
